hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the five-stage ARM pipeline (F, D, E, M, W).
- Sequences the fetch, decode and execute pipeline registers by generating stall and flush controls.
- Selects the execute-stage forwarding paths.
- Holds the execute stage for multi-cycle multiplies with an internal busy FSM.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/mul_busy_fsm.sv | 54 +++++
 rtl/hazard_ctrl.sv | 105 ++++++++++
 tb/tb_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds no logic; pulls in no latency or flow-control behaviour.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/mul_busy_fsm.sv
// Multiply occupancy tracker: busy for MUL_LAT-1 cycles after an unkilled start.
// Latency: busy rises the cycle after start. No backpressure; the stall outputs are driven from busy.
module mul_busy_fsm
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic kill,
    output logic busy
);

    // The entry cycle counts toward MUL_LAT, so the count covers the remaining BUSY cycles minus one.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

    mc_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: forwarding selects, stall/flush controls, perf counters.
// Latency: controls are combinational; counters show an event one cycle later. Stalls are the pipeline's backpressure.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA3D,
    input  logic             UseAD,
    input  logic             UseBD,
    input  logic             UseCD,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MulStartE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MulBusyE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    fwd_sel_t         fwd_a, fwd_b;
    logic             ldr_stall, pc_pend;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    mul_busy_fsm #(.MUL_LAT(MUL_LAT)) u_mul_fsm (
        .clk   (clk),
        .reset (reset),
        .start (MulStartE),
        .kill  (BranchTakenE),
        .busy  (MulBusyE)
    );

    // M beats W since it holds the younger result; R15 always reads the live PC path.
    always_comb begin
        fwd_a = FWD_RF;
        if (RegWriteM && (WA3M == RA1E) && (RA1E != PC_REG))      fwd_a = FWD_MEM;
        else if (RegWriteW && (WA3W == RA1E) && (RA1E != PC_REG)) fwd_a = FWD_WB;

        fwd_b = FWD_RF;
        if (RegWriteM && (WA3M == RA2E) && (RA2E != PC_REG))      fwd_b = FWD_MEM;
        else if (RegWriteW && (WA3W == RA2E) && (RA2E != PC_REG)) fwd_b = FWD_WB;
    end

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    assign ldr_stall = MemtoRegE && RegWriteE &&
                       ((UseAD && (RA1D == WA3E)) ||
                        (UseBD && (RA2D == WA3E)) ||
                        (UseCD && (RA3D == WA3E)));
    assign pc_pend   = PCSrcD || PCSrcE || PCSrcM;

    assign StallF = ldr_stall || pc_pend || MulBusyE;
    assign StallD = ldr_stall || MulBusyE;
    assign StallE = MulBusyE;
    assign FlushD = (pc_pend || PCSrcW || BranchTakenE) && !MulBusyE;
    assign FlushE = (ldr_stall || BranchTakenE) && !MulBusyE;
    assign FlushM = MulBusyE;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (FlushE && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control vectors queued at drive time, popped at sample time.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] RA1D, RA2D, RA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic UseAD, UseBD, UseCD, RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA3D(RA3D),
        .UseAD(UseAD), .UseBD(UseBD), .UseCD(UseCD),
        .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MulBusyE(MulBusyE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    // {FA, FB, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE}
    logic [12:0] obs;
    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusyE};

    logic [12:0] sb_q[$];
    string       sb_name[$];
    logic [12:0] exp_v;
    string       exp_n;
    int          checks   = 0;
    int          failures = 0;
    logic [CNT_W-1:0] exp_scnt, exp_fcnt;

    function automatic logic [12:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic b);
        return {fa, fb, sf, sd, se, fd, fe, fm, b};
    endfunction

    task automatic push(input string n, input logic [12:0] v);
        sb_q.push_back(v);
        sb_name.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {RA1D, RA2D, RA3D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {UseAD, UseBD, UseCD, RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE} = '0;
    endtask

    task automatic bump_stall();
        if (exp_scnt != CNT_MAX) exp_scnt = exp_scnt + 1'b1;
    endtask

    task automatic bump_flush();
        if (exp_fcnt != CNT_MAX) exp_fcnt = exp_fcnt + 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        push("reset_outputs", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
        checks++;
        if (obs !== exp_v) begin
            failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
        end
        checks++;
        if (StallCnt !== '0 || FlushCnt !== '0) begin
            failures++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", StallCnt, FlushCnt);
        end
        tick();
        reset = 1'b0;
        exp_scnt = '0;
        exp_fcnt = '0;
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
                    push("fwd_a_mem", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                end
                1: begin
                    RA1E = 3; WA3M = 3; RegWriteM = 0; WA3W = 3; RegWriteW = 1;
                    push("fwd_a_wb", ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                end
                2: begin
                    RA1E = 15; RA2E = 15; WA3M = 15; RegWriteM = 1; WA3W = 15; RegWriteW = 1;
                    push("fwd_r15_never", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                end
                3: begin
                    RA1E = 2; RA2E = 7; WA3M = 7; RegWriteM = 1; WA3W = 2; RegWriteW = 1;
                    push("fwd_b_mem_a_wb", ev(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0));
                end
                default: begin
                    RA1E = 9; RA2E = 7; WA3M = 2; RegWriteM = 1; WA3W = 7; RegWriteW = 1;
                    push("fwd_b_wb_a_none", ev(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
                end
            endcase
            @(negedge clk);
            exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5; UseBD = 1;
        push("ldr_use_b", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0));
        bump_stall(); bump_flush();
        @(negedge clk);
        exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
        checks++;
        if (obs !== exp_v) begin
            failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
        end
        tick();
        UseBD = 0;
        push("ldr_unused_src", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
        checks++;
        if (obs !== exp_v) begin
            failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
        end
        checks++;
        if (StallCnt !== exp_scnt || FlushCnt !== exp_fcnt) begin
            failures++; $display("FAIL ldr_counters: got %0d/%0d expected %0d/%0d",
                                 StallCnt, FlushCnt, exp_scnt, exp_fcnt);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_multiply();
        clear_inputs();
        MulStartE = 1;
        push("mul_entry", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < MUL_LAT - 1; c++) begin
            push("mul_busy", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1));
            bump_stall();
        end
        push("mul_done", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c <= MUL_LAT; c++) begin
            // Load-use inputs while busy must not raise FlushE.
            if (c == 2) begin
                MemtoRegE = 1; RegWriteE = 1; WA3E = 4; RA1D = 4; UseAD = 1;
            end
            @(negedge clk);
            exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL %s[%0d]: got %b expected %b", exp_n, c, obs, exp_v);
            end
            tick();
            clear_inputs();
        end
    endtask

    task automatic test_branch_pc();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    BranchTakenE = 1;
                    push("branch_taken", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0));
                    bump_flush();
                end
                1: begin
                    PCSrcD = 1;
                    push("pcsrc_d", ev(2'b00, 2'b00, 1, 0, 0, 1, 0, 0, 0));
                end
                2: begin
                    PCSrcW = 1;
                    push("pcsrc_w", ev(2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));
                end
                3: begin
                    PCSrcE = 1; MemtoRegE = 1; RegWriteE = 1; WA3E = 6; RA3D = 6; UseCD = 1;
                    push("ldr_plus_pc", ev(2'b00, 2'b00, 1, 1, 0, 1, 1, 0, 0));
                    bump_stall(); bump_flush();
                end
                default: begin
                    MulStartE = 1; BranchTakenE = 1;
                    push("mul_squash", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0));
                    bump_flush();
                end
            endcase
            @(negedge clk);
            exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
            end
            tick();
        end
        clear_inputs();
        push("squash_stays_idle", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
        checks++;
        if (obs !== exp_v) begin
            failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
        end
        checks++;
        if (StallCnt !== exp_scnt || FlushCnt !== exp_fcnt) begin
            failures++; $display("FAIL event_counters: got %0d/%0d expected %0d/%0d",
                                 StallCnt, FlushCnt, exp_scnt, exp_fcnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        clear_inputs();
        MulStartE = 1;
        tick();
        clear_inputs();
        tick();
        push("busy_before_reset", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1));
        reset = 1'b1;
        @(negedge clk);
        exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
        checks++;
        if (obs !== exp_v) begin
            failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
        end
        tick();
        reset = 1'b0;
        exp_scnt = '0;
        exp_fcnt = '0;
        push("abort_after_reset", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        exp_v = sb_q.pop_front(); exp_n = sb_name.pop_front();
        checks++;
        if (obs !== exp_v) begin
            failures++; $display("FAIL %s: got %b expected %b", exp_n, obs, exp_v);
        end
        checks++;
        if (StallCnt !== exp_scnt || FlushCnt !== exp_fcnt) begin
            failures++; $display("FAIL reset_mid_counters: got %0d/%0d expected 0/0", StallCnt, FlushCnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 8; RA1D = 8; UseAD = 1;
        for (int c = 0; c < (1 << CNT_W) + 5; c++) begin
            bump_stall(); bump_flush();
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (StallCnt !== exp_scnt || StallCnt !== CNT_MAX) begin
            failures++; $display("FAIL stall_saturate: got %0d expected %0d", StallCnt, CNT_MAX);
        end
        checks++;
        if (FlushCnt !== exp_fcnt || FlushCnt !== CNT_MAX) begin
            failures++; $display("FAIL flush_saturate: got %0d expected %0d", FlushCnt, CNT_MAX);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        exp_scnt = '0;
        exp_fcnt = '0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_multiply();
        test_branch_pc();
        test_reset_mid_mul();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
